iob_vexbus_responder: RTL and testbench

//  IOb native-bus responder that forwards each IOb request onto a VexRiscv-style dBus cmd/rsp

---
 rtl/iob_vexbus_responder.sv | 171 +++++++++++++++++
 tb/tb_iob_vexbus_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_vexbus_responder.sv
// IOb native-bus slave bridged onto a VexRiscv dBus cmd/rsp stream master.
// Optional read-response watchdog enabled by IOB_VEXBUS_RESPONDER_TIMEOUT_EN.
module iob_vexbus_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iob_valid,
    input  logic [ADDR_W-1:0]   iob_addr,
    input  logic [DATA_W-1:0]   iob_wdata,
    input  logic [DATA_W/8-1:0] iob_wstrb,
    output logic [DATA_W-1:0]   iob_rdata,
    output logic                iob_ready,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_wr,
    output logic [ADDR_W-1:0]   cmd_address,
    output logic [DATA_W-1:0]   cmd_data,
    output logic [DATA_W/8-1:0] cmd_mask,
    output logic [1:0]          cmd_size,
    input  logic                rsp_valid,
    input  logic [DATA_W-1:0]   rsp_data,
    input  logic                rsp_error,
    output logic                bus_err
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_RSP,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   mask_q, mask_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   iob_rdata_q, iob_rdata_d;

`ifdef IOB_VEXBUS_RESPONDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            wr_q        <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            iob_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_valid_q <= cmd_valid_d;
            ready_q     <= ready_d;
            iob_rdata_q <= iob_rdata_d;
        end
    end

`ifdef IOB_VEXBUS_RESPONDER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cmd_valid_d = 1'b0;
        ready_d     = 1'b0;
        iob_rdata_d = '0;
`ifdef IOB_VEXBUS_RESPONDER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (iob_valid) begin
                    addr_d      = iob_addr;
                    wdata_d     = iob_wdata;
                    wr_d        = |iob_wstrb;
                    mask_d      = (|iob_wstrb) ? iob_wstrb : '1;
                    cmd_valid_d = 1'b1;
                    state_d     = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    // writes complete on accept; reads wait for the stream response
                    if (wr_q) begin
                        ready_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RSP;
`ifdef IOB_VEXBUS_RESPONDER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_valid) begin
                    rdata_d     = rsp_data;
                    err_d       = err_q | rsp_error;
                    ready_d     = 1'b1;
                    iob_rdata_d = rsp_data;
                    state_d     = S_RESP;
                end
`ifdef IOB_VEXBUS_RESPONDER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d     = DATA_W'(32'hDEAD_BEEF);
                    err_d       = 1'b1;
                    ready_d     = 1'b1;
                    iob_rdata_d = DATA_W'(32'hDEAD_BEEF);
                    cnt_d       = CNT_W'(TIMEOUT);
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign iob_ready   = ready_q;
    assign iob_rdata   = iob_rdata_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_wr      = wr_q;
    assign cmd_address = addr_q;
    assign cmd_data    = wdata_q;
    assign cmd_mask    = mask_q;
    assign cmd_size    = 2'd2;
    assign bus_err     = err_q;

endmodule

// File: tb/tb_iob_vexbus_responder.sv
// Randomized bench for iob_vexbus_responder with a transaction-level reference model.
// Define IOB_VEXBUS_RESPONDER_TIMEOUT_EN to exercise the read-response watchdog.
module tb_iob_vexbus_responder;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          iob_valid = 1'b0;
    logic [AW-1:0] iob_addr = '0;
    logic [DW-1:0] iob_wdata = '0;
    logic [SW-1:0] iob_wstrb = '0;
    logic [DW-1:0] iob_rdata;
    logic          iob_ready;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic          cmd_wr;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_mask;
    logic [1:0]    cmd_size;
    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_data = '0;
    logic          rsp_error = 1'b0;
    logic          bus_err;

    iob_vexbus_responder #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iob_valid  (iob_valid),
        .iob_addr   (iob_addr),
        .iob_wdata  (iob_wdata),
        .iob_wstrb  (iob_wstrb),
        .iob_rdata  (iob_rdata),
        .iob_ready  (iob_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_address(cmd_address),
        .cmd_data   (cmd_data),
        .cmd_mask   (cmd_mask),
        .cmd_size   (cmd_size),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_error  (rsp_error),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_g = 0;
    int last_ready = 0;
    logic model_err = 1'b0;

    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // nrsp < 0 means the stream never answers the read
    task automatic txn(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] ws, input int dly, input int nrsp,
                       input logic rerr, input logic [DW-1:0] rd,
                       input bit stray, input bit b2b);
        logic          wr;
        logic [SW-1:0] exp_mask;
        logic [DW-1:0] exp_rd;
        int            exp_lat;
        int            cyc;
        int            cmd_cyc;
        int            since;
        int            ready_cnt;
        int            bound;
        bit            acc;
        bit            done;
        bit            hang;
        wr       = |ws;
        exp_mask = wr ? ws : {SW{1'b1}};
        exp_rd   = '0;
        hang     = 1'b0;
        if (wr) begin
            exp_lat = 3 + dly;
        end else if (nrsp >= 0) begin
            exp_rd    = rd;
            exp_lat   = 3 + dly + nrsp;
            model_err = model_err | rerr;
        end else begin
`ifdef IOB_VEXBUS_RESPONDER_TIMEOUT_EN
            exp_rd    = 32'hDEAD_BEEF;
            exp_lat   = 3 + dly + TMO;
            model_err = 1'b1;
`else
            hang      = 1'b1;
            exp_lat   = 0;
`endif
        end
        bound     = hang ? 1000 : exp_lat + 20;
        cyc       = 0;
        cmd_cyc   = 0;
        since     = 0;
        ready_cnt = 0;
        acc       = 1'b0;
        done      = 1'b0;
        @(negedge clk);
        iob_valid = 1'b1;
        iob_addr  = a;
        iob_wdata = wd;
        iob_wstrb = ws;
        while (!done) begin
            @(negedge clk);
            cyc++;
            rsp_valid = 1'b0;
            rsp_error = 1'b0;
            cmd_ready = 1'b0;
            if (iob_ready) begin
                ready_cnt++;
                if (!hang) begin
                    chk("latency", 64'(cyc + 1), 64'(exp_lat));
                    chk("rdata", 64'(iob_rdata), 64'(exp_rd));
                    chk("bus_err", 64'(bus_err), 64'(model_err));
                    chk("cmd_valid_in_resp", 64'(cmd_valid), 64'd0);
                    iob_valid  = 1'b0;
                    iob_wstrb  = '0;
                    last_ready = cyc_g;
                    done       = 1'b1;
                end
            end else if (cmd_valid) begin
                chk("cmd_after_accept", 64'(acc), 64'd0);
                if (cmd_cyc == 0 && b2b)
                    chk("b2b_gap", 64'(cyc_g - last_ready), 64'd2);
                chk("cmd_addr", 64'(cmd_address), 64'(a));
                chk("cmd_data", 64'(cmd_data), 64'(wd));
                chk("cmd_mask", 64'(cmd_mask), 64'(exp_mask));
                chk("cmd_wr", 64'(cmd_wr), 64'(wr));
                chk("cmd_size", 64'(cmd_size), 64'd2);
                cmd_cyc++;
                if (cmd_cyc > dly) begin
                    cmd_ready = 1'b1;
                    acc       = 1'b1;
                end
                if (stray) begin
                    rsp_valid = 1'b1;
                    rsp_error = 1'b1;
                    rsp_data  = $urandom;
                end
            end else if (acc && !wr) begin
                since++;
                if (since == nrsp) begin
                    rsp_valid = 1'b1;
                    rsp_data  = rd;
                    rsp_error = rerr;
                end
            end
            if (!done && cyc >= bound) begin
                if (hang) begin
                    chk("hang_no_ready", 64'(ready_cnt), 64'd0);
                end else begin
                    chk("ready_timeout", 64'(cyc), 64'(exp_lat));
                end
                iob_valid = 1'b0;
                done      = 1'b1;
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 64'(iob_ready), 64'd0);
        chk({tag, "_rdata"}, 64'(iob_rdata), 64'd0);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_cmd_wr"}, 64'(cmd_wr), 64'd0);
        chk({tag, "_cmd_addr"}, 64'(cmd_address), 64'd0);
        chk({tag, "_cmd_data"}, 64'(cmd_data), 64'd0);
        chk({tag, "_cmd_mask"}, 64'(cmd_mask), 64'd0);
        chk({tag, "_cmd_size"}, 64'(cmd_size), 64'd2);
        chk({tag, "_bus_err"}, 64'(bus_err), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        iob_valid = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        #1;
        model_err = 1'b0;
        chk_outputs_zero("rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int events;
        logic [SW-1:0] ws;
        #1;
        chk_outputs_zero("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // directed: full write, stalled read, erroring read, byte write then read
        txn(32'h100, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b0, '0, 1'b0, 1'b0);
        txn(32'h204, 32'h0, 4'h0, 4, 2, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
        txn(32'h208, 32'h0, 4'h0, 0, 1, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1);
        txn(32'h20C, 32'h0, 4'h0, 1, 3, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
        txn(32'h300, 32'h0000_5500, 4'b0100, 1, 0, 1'b0, '0, 1'b1, 1'b1);
        txn(32'h304, 32'h0, 4'h0, 0, 1, 1'b0, 32'h7777_1111, 1'b1, 1'b1);

        // reset while a read waits for its response
        @(negedge clk);
        iob_valid = 1'b1;
        iob_addr  = 32'h400;
        iob_wstrb = '0;
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        iob_valid = 1'b0;
        rst       = 1'b0;
        cmd_ready = 1'b0;
        #1;
        model_err = 1'b0;
        chk_outputs_zero("mid_rst");
        @(negedge clk);
        rst       = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 32'h5555_AAAA;
        rsp_error = 1'b1;
        events    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_error = 1'b0;
            events += int'(iob_ready) + int'(cmd_valid) + int'(bus_err);
        end
        chk("post_rst_quiet", 64'(events), 64'd0);
        txn(32'h408, 32'h1, 4'h3, 0, 0, 1'b0, '0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            ws = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
            txn($urandom & 32'hFFFF_FFFC, $urandom, ws,
                $urandom_range(0, 3), $urandom_range(1, 4),
                ($urandom_range(0, 7) == 0), $urandom,
                ($urandom_range(0, 3) == 0), 1'b1);
        end

        // read that never gets a response
        txn(32'h500, 32'h0, 4'h0, 0, -1, 1'b0, '0, 1'b0, 1'b1);
        do_reset();
        txn(32'h504, 32'h0, 4'h0, 0, 2, 1'b0, 32'hFEED_0001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
